// File: rtl/fifo_wr_arbiter.sv
// Write-side controller for the dual-clock FIFO: round-robin write-port arbiter, write pointers
// and registered full flag. Define FIFO_ARB_BURST_EN to lock the winner for up to BURST_LEN words.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                          clk_A,
  input  logic                          rst_A,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          full,
  output logic [ADDR_WIDTH:0]           wr_ptr_gray,
  input  logic [ADDR_WIDTH:0]           rd_ptr_gray
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  if (NUM_REQ < 2 || NUM_REQ > 16 || IDX_W != $clog2(NUM_REQ) || ADDR_WIDTH < 2 ||
      BURST_LEN < 1 || BURST_LEN > 16) begin : g_param_check
    $error("fifo_wr_arbiter: illegal parameter combination");
  end

  logic [PW-1:0]    wbin_q, wbin_next, gray_next, full_cmp;
  logic [PW-1:0]    wr_ptr_gray_q, rq1_q, rq2_q;
  logic             full_q;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, base_idx, win_idx, gnt_idx;
  logic             win_found, gnt_valid;

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  logic             lock_q, lock_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  // While locked the rotation continues from the owner once the lock is dropped.
  assign base_idx = lock_q ? owner_q : rr_ptr_q;
`else
  assign base_idx = rr_ptr_q;
`endif

  // First set request after base_idx, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(base_idx) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  always_comb begin
    gnt_valid   = 1'b0;
    gnt_idx     = '0;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (rst_A) begin
      lock_d = 1'b0;
    end else if (full_q) begin
      if (lock_q) begin
        lock_d      = 1'b0;
        rr_ptr_d    = owner_q;
        burst_cnt_d = '0;
      end
    end else if (lock_q && req[owner_q]) begin
      gnt_valid   = 1'b1;
      gnt_idx     = owner_q;
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
      if (burst_cnt_d == CNT_W'(BURST_LEN)) begin
        lock_d      = 1'b0;
        rr_ptr_d    = owner_q;
        burst_cnt_d = '0;
      end
    end else begin
      // Owner dropped its request: release and re-arbitrate in the same cycle.
      if (lock_q) begin
        lock_d      = 1'b0;
        rr_ptr_d    = owner_q;
        burst_cnt_d = '0;
      end
      if (win_found) begin
        gnt_valid = 1'b1;
        gnt_idx   = win_idx;
        if (BURST_LEN == 1) begin
          rr_ptr_d = win_idx;
        end else begin
          lock_d      = 1'b1;
          owner_d     = win_idx;
          burst_cnt_d = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_A or posedge rst_A) begin
    if (rst_A) begin
      lock_q      <= 1'b0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    rr_ptr_d  = rr_ptr_q;
    if (!rst_A && !full_q && win_found) begin
      gnt_valid = 1'b1;
      gnt_idx   = win_idx;
      rr_ptr_d  = win_idx;
    end
  end
`endif

  assign grant   = gnt_valid ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign wr_en   = gnt_valid;
  assign wr_data = gnt_valid ? req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign wbin_next = wbin_q + PW'(wr_en);
  assign gray_next = wbin_next ^ (wbin_next >> 1);
  // Full when the write pointer is one lap ahead of the synchronised read pointer.
  assign full_cmp  = {~rq2_q[PW-1:PW-2], rq2_q[PW-3:0]};

  always_ff @(posedge clk_A or posedge rst_A) begin
    if (rst_A) begin
      rq1_q         <= '0;
      rq2_q         <= '0;
      wbin_q        <= '0;
      wr_ptr_gray_q <= '0;
      full_q        <= 1'b0;
      rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
    end else begin
      rq1_q         <= rd_ptr_gray;
      rq2_q         <= rq1_q;
      wbin_q        <= wbin_next;
      wr_ptr_gray_q <= gray_next;
      full_q        <= (gray_next == full_cmp);
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign full        = full_q;
  assign wr_ptr_gray = wr_ptr_gray_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: fill/full/release table, round-robin, reset, burst, wrap.
module tb_fifo_wr_arbiter;

  logic        clk_A;
  logic        rst_A;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic [3:0]  wr_ptr_gray;
  logic [3:0]  rd_ptr_gray;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rd;
    logic [3:0] grant;
    logic       full;
    logic [3:0] gray;
  } vec_t;

  vec_t       vecs[14];
  logic [3:0] rr_exp[5];
  logic [3:0] bu_exp[8];
  logic [3:0] gseq[8];

  fifo_wr_arbiter #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .NUM_REQ   (4),
    .IDX_W     (2),
    .BURST_LEN (4)
  ) dut (
    .clk_A      (clk_A),
    .rst_A      (rst_A),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray)
  );

  initial clk_A = 1'b0;
  always #5 clk_A = ~clk_A;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_data(input logic [3:0] g);
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < 4; i++) if (g[i]) d = req_data[i*8 +: 8];
    return d;
  endfunction

  function automatic logic [3:0] gray4(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic check_all(input string tag, input logic [3:0] g, input logic f,
                           input logic [3:0] gr);
    check({tag, " grant"}, 32'(grant), 32'(g));
    check({tag, " wr_en"}, 32'(wr_en), 32'(|g));
    check({tag, " wr_data"}, 32'(wr_data), 32'(exp_data(g)));
    check({tag, " full"}, 32'(full), 32'(f));
    check({tag, " wr_ptr_gray"}, 32'(wr_ptr_gray), 32'(gr));
  endtask

  // Called at a negedge; returns at the next negedge with reset released.
  task automatic do_reset();
    rst_A       = 1'b1;
    req         = 4'b0000;
    rd_ptr_gray = 4'b0000;
    @(negedge clk_A);
    rst_A = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_A       = 1'b1;
    req         = 4'b0000;
    rd_ptr_gray = 4'b0000;
    req_data    = 32'hA3A2A1A0;

    // Single requester fills the FIFO, then one read frees one slot.
    vecs[0]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0001};
    vecs[2]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0011};
    vecs[3]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0010};
    vecs[4]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0110};
    vecs[5]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0111};
    vecs[6]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0101};
    vecs[7]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 4'b0100};
    vecs[8]  = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b1100};
    vecs[9]  = '{4'b0100, 4'b0001, 4'b0000, 1'b1, 4'b1100};
    vecs[10] = '{4'b0100, 4'b0001, 4'b0000, 1'b1, 4'b1100};
    vecs[11] = '{4'b0100, 4'b0001, 4'b0000, 1'b1, 4'b1100};
    vecs[12] = '{4'b0100, 4'b0001, 4'b0100, 1'b0, 4'b1100};
    vecs[13] = '{4'b0100, 4'b0001, 4'b0000, 1'b1, 4'b1101};

    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100};
`ifdef FIFO_ARB_BURST_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    bu_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bu_exp = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif

    repeat (2) @(negedge clk_A);
    check_all("reset", 4'b0000, 1'b0, 4'b0000);
    rst_A = 1'b0;

    for (int i = 0; i < 14; i++) begin
      req         = vecs[i].req;
      rd_ptr_gray = vecs[i].rd;
      #1;
      check_all($sformatf("fill[%0d]", i), vecs[i].grant, vecs[i].full, vecs[i].gray);
      @(negedge clk_A);
    end

    // Round-robin under full contention.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req = 4'b1111;
      #1;
      check_all($sformatf("rr[%0d]", i), rr_exp[i], 1'b0, gseq[i]);
      @(negedge clk_A);
    end
    #1;
    check_all("rr[5]", 4'b0010, 1'b0, 4'b0111);

    // Asynchronous reset mid-stream, then requester 0 wins first.
    rst_A = 1'b1;
    #1;
    check_all("midrst", 4'b0000, 1'b0, 4'b0000);
    @(negedge clk_A);
    rst_A = 1'b0;
    #1;
    check_all("postrst", 4'b0001, 1'b0, 4'b0000);
    @(negedge clk_A);

    // Two requesters: burst lock vs. per-word rotation.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req = 4'b0011;
      #1;
      check_all($sformatf("burst[%0d]", i), bu_exp[i], 1'b0, gseq[i]);
      @(negedge clk_A);
    end
    #1;
    check_all("burst_full", 4'b0000, 1'b1, 4'b1100);
    @(negedge clk_A);

    // 20 writes with a trailing reader: pointer wraps past 15, never full.
    do_reset();
    for (int n = 0; n < 20; n++) begin
      req            = 4'b0001;
      req_data[7:0]  = 8'(n + 8'h30);
      rd_ptr_gray    = (n >= 2) ? gray4(n - 2) : 4'b0000;
      #1;
      check($sformatf("wrap[%0d] grant", n), 32'(grant), 32'h1);
      check($sformatf("wrap[%0d] full", n), 32'(full), 32'h0);
      check($sformatf("wrap[%0d] wr_ptr_gray", n), 32'(wr_ptr_gray), 32'(gray4(n)));
      check($sformatf("wrap[%0d] wr_data", n), 32'(wr_data), 32'(n + 8'h30));
      @(negedge clk_A);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side controller for the team's dual-clock FIFO. It lives entirely in the clk_A domain and shares the FIFO write port between NUM_REQ requesters using round-robin arbitration. It keeps the authoritative binary and Gray write pointers and generates the registered full flag from a two-flop-synchronised Gray read pointer. Its wr_en, wr_data and full outputs connect directly to the FIFO write port and full input, and its Gray write pointer feeds the clk_B-side empty logic.

## Interface
- DATA_WIDTH, 8, FIFO word width
- ADDR_WIDTH, 3, FIFO address bits; pointers are ADDR_WIDTH+1 bits wide
- NUM_REQ, 4, number of requesters, 2..16
- IDX_W, 2, clog2(NUM_REQ)
- BURST_LEN, 4, maximum words per locked burst, 1..16 (used only with burst lock)
- clk_A  in  1  write-domain clock
- rst_A  in  1  reset, asynchronous, active-high; clock clk_A
- req  in  NUM_REQ  per-requester write request; level, held until granted
- req_data  in  NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
- grant  out  NUM_REQ  one-hot, combinational; grant[i]=1 means req_data[i] is written at this edge
- wr_en  out  1  FIFO write enable, equal to |grant
- wr_data  out  DATA_WIDTH  data of the granted requester; 0 when no grant
- full  out  1  registered full flag, driven to the FIFO full input
- wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, sent to clk_B
- rd_ptr_gray  in  ADDR_WIDTH+1  registered Gray read pointer from clk_B (asynchronous to clk_A)

## Operation
- Synchroniser: rq1 <= rd_ptr_gray; rq2 <= rq1. No other logic touches rd_ptr_gray.
- Shadow pointer wbin (ADDR_WIDTH+1 bits) increments by 1 mod 2^(ADDR_WIDTH+1) on each edge with wr_en=1. It stays equal to the FIFO's own wr_ptr because both share the same reset. wr_ptr_gray <= wbin_next ^ (wbin_next >> 1).
- full <= (gray(wbin_next) == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]}).
- Arbitration is combinational and gated by ~full and ~rst_A. It searches req starting at (rr_ptr+1) mod NUM_REQ and grants the first set bit. rr_ptr <= winner index on each grant.
- Because wr_en is already gated by full, the FIFO's internal wr_en & ~full never drops a granted word. Requesters must treat grant as their acknowledge.
- Reset values: wbin 0, wr_ptr_gray 0, rq1/rq2 0, full 0, rr_ptr NUM_REQ-1 (requester 0 wins first), lock 0, burst_cnt 0. grant, wr_en and wr_data are 0 while rst_A is high.
- Reset mid-operation: all state clears immediately; a request that was pending but not granted is not written. rst_A and rst_B must be asserted together so that the pointers stay consistent.

## Timing
- Grant-to-write latency is 0: the word is written on the same clk_A edge on which grant is high. A requester holding req continuously is granted at most once every NUM_REQ cycles under full contention.
- Full assertion: full rises on the same edge as the write that fills the last free slot. The first grant suppression is in the following cycle.
- Full release: a rd_ptr_gray change is visible in rq2 after 2 clk_A edges, and full falls on the 3rd edge (2–3 cycles depending on phase).
- Wrap-around: wbin rolls over from 2^(ADDR_WIDTH+1)-1 to 0; the MSB/2nd-MSB compare handles the wrap, with no special case.
- Simultaneous events: when a write and a read-pointer update land on the same edge, full is computed from the pre-update rq2. This is conservative and never causes overflow.

## Configuration
- FIFO_ARB_BURST_EN defined: the winner becomes locked (lock=1, burst_cnt=1). While locked and req[owner] stays high, the owner keeps the grant on consecutive non-full cycles. Lock releases after BURST_LEN words, or when req[owner] drops, or when full asserts. rr_ptr advances only at release.
- Undefined: lock and burst_cnt are not generated, and the grant rotates after every word.

## Test plan
- Reset, then only req[2]=1 with rd_ptr_gray held at 0: exactly 8 consecutive grants of 0100. full=1 on the edge of the 8th write, grant=0 afterwards, wr_ptr_gray=1100.
- req=1111 continuously with a reader draining: grant sequence 0001, 0010, 0100, 1000, 0001; wr_data matches each req_data slice.
- FIFO full, then rd_ptr_gray 0000->0001: full stays 1 for 2 edges, falls on the 3rd, and one grant follows.
- 20 writes interleaved with reads so that wbin wraps past 15 to 0: no false full, the FIFO receives the writes in order, wr_ptr_gray sequence is valid Gray code.
- Assert rst_A for 1 cycle mid-stream with 5 words written: all outputs 0 immediately; after release requester 0 wins first.
- With FIFO_ARB_BURST_EN, req=0011: grants 0001 ×4, then 0010 ×4. Without the macro: alternating 0001 and 0010.
